// File: rtl/dmi_pkg.sv
// Shared DMI encodings and the bridge state type.
package dmi_pkg;

  localparam int DMI_DATA_W = 32;

  localparam logic [1:0] DMI_OP_NOP   = 2'd0;
  localparam logic [1:0] DMI_OP_READ  = 2'd1;
  localparam logic [1:0] DMI_OP_WRITE = 2'd2;

  localparam logic [1:0] DMI_RESP_SUCCESS = 2'd0;
  localparam logic [1:0] DMI_RESP_FAILED  = 2'd2;
  localparam logic [1:0] DMI_RESP_BUSY    = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_RET,
    ST_DRAIN
  } dmi_state_e;

endpackage

// File: rtl/dmi_sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones.
module dmi_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count up on inc until the value reaches all-ones, then hold.
  always_ff @(posedge clk) begin
    // NOTE: flops are written with <= so every register samples pre-edge values.
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dmi_timeout_bridge.sv
// DMI bridge between the DTM and the debug module. Forwards one transaction
// at a time, synthesizes a FAILED response if the DM stays silent, and drains
// the late response after a timeout so it never pairs with a later request.
module dmi_timeout_bridge
  import dmi_pkg::*;
#(
  parameter int ADDR_W  = 7,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  in_req_valid,
  output logic                  in_req_ready,
  input  logic [ADDR_W-1:0]     in_req_addr,
  input  logic [1:0]            in_req_op,
  input  logic [DMI_DATA_W-1:0] in_req_data,

  output logic                  in_resp_valid,
  input  logic                  in_resp_ready,
  output logic [1:0]            in_resp_resp,
  output logic [DMI_DATA_W-1:0] in_resp_data,

  output logic                  out_req_valid,
  input  logic                  out_req_ready,
  output logic [ADDR_W-1:0]     out_req_addr,
  output logic [1:0]            out_req_op,
  output logic [DMI_DATA_W-1:0] out_req_data,

  input  logic                  out_resp_valid,
  output logic                  out_resp_ready,
  input  logic [1:0]            out_resp_resp,
  input  logic [DMI_DATA_W-1:0] out_resp_data,

  output logic [CNT_W-1:0]      timeout_count,
  output logic [CNT_W-1:0]      stray_count
);

  // Timer counts 0..TIMEOUT-1; reaching the last value ends a wait window.
  localparam int              TMR_W    = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  dmi_state_e            state_q, state_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [1:0]            op_q, op_d;
  logic [DMI_DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]            resp_q, resp_d;
  logic [DMI_DATA_W-1:0] rdata_q, rdata_d;
  logic                  drain_q, drain_d;
  logic                  resp_ready_q;
  logic                  resp_hs;
  logic                  timeout_inc;
  logic                  stray_inc;

  assign resp_hs = out_resp_valid && resp_ready_q;

  // Next-state, latch updates and counter events for the transaction FSM.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    timer_d     = timer_q;
    addr_d      = addr_q;
    op_d        = op_q;
    wdata_d     = wdata_q;
    resp_d      = resp_q;
    rdata_d     = rdata_q;
    drain_d     = drain_q;
    timeout_inc = 1'b0;
    stray_inc   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        stray_inc = resp_hs;
        if (in_req_valid) begin
          addr_d  = in_req_addr;
          op_d    = in_req_op;
          wdata_d = in_req_data;
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        stray_inc = resp_hs;
        if (out_req_ready) begin
          timer_d = '0;
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        // A response on the expiry cycle takes priority over the timeout.
        if (resp_hs) begin
          resp_d  = out_resp_resp;
          rdata_d = out_resp_data;
          state_d = ST_RET;
        end else if (timer_q == TMR_LAST) begin
          resp_d      = DMI_RESP_FAILED;
          rdata_d     = '0;
          drain_d     = 1'b1;
          timeout_inc = 1'b1;
          state_d     = ST_RET;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      ST_RET: begin
        if (in_resp_ready) begin
          timer_d = '0;
          state_d = drain_q ? ST_DRAIN : ST_IDLE;
        end
      end

      ST_DRAIN: begin
        // The first late response is swallowed silently; give up after TIMEOUT cycles.
        if (resp_hs || (timer_q == TMR_LAST)) begin
          drain_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latch registers; out_resp_ready is registered so it stays low in reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: datapath latches are reset as well so outputs read as zero straight after reset.
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      addr_q       <= '0;
      op_q         <= '0;
      wdata_q      <= '0;
      resp_q       <= '0;
      rdata_q      <= '0;
      drain_q      <= 1'b0;
      resp_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      addr_q       <= addr_d;
      op_q         <= op_d;
      wdata_q      <= wdata_d;
      resp_q       <= resp_d;
      rdata_q      <= rdata_d;
      drain_q      <= drain_d;
      resp_ready_q <= (state_d != ST_RET);
    end
  end

  assign in_req_ready   = (state_q == ST_IDLE);
  assign out_req_valid  = (state_q == ST_REQ);
  assign in_resp_valid  = (state_q == ST_RET);
  assign out_resp_ready = resp_ready_q;

  assign out_req_addr = addr_q;
  assign out_req_op   = op_q;
  assign out_req_data = wdata_q;
  assign in_resp_resp = resp_q;
  assign in_resp_data = rdata_q;

  dmi_sat_counter #(.CNT_W(CNT_W)) u_timeout_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (timeout_inc),
    .count (timeout_count)
  );

  dmi_sat_counter #(.CNT_W(CNT_W)) u_stray_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stray_inc),
    .count (stray_count)
  );

endmodule

// File: tb/tb_dmi_timeout_bridge.sv
// Bench for dmi_timeout_bridge: hand-derived vector table, directed corner
// sequences and randomized traffic checked against a transaction-level model.
module tb_dmi_timeout_bridge;
  import dmi_pkg::*;

  localparam int ADDR_W  = 7;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int OUT_W   = 2 + ADDR_W + 2 + 32 + 2 + 2 + 32 + 2 * CNT_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_req_valid = 1'b0;
  logic              in_req_ready;
  logic [ADDR_W-1:0] in_req_addr = '0;
  logic [1:0]        in_req_op = '0;
  logic [31:0]       in_req_data = '0;
  logic              in_resp_valid;
  logic              in_resp_ready = 1'b0;
  logic [1:0]        in_resp_resp;
  logic [31:0]       in_resp_data;
  logic              out_req_valid;
  logic              out_req_ready = 1'b0;
  logic [ADDR_W-1:0] out_req_addr;
  logic [1:0]        out_req_op;
  logic [31:0]       out_req_data;
  logic              out_resp_valid = 1'b0;
  logic              out_resp_ready;
  logic [1:0]        out_resp_resp = '0;
  logic [31:0]       out_resp_data = '0;
  logic [CNT_W-1:0]  timeout_count;
  logic [CNT_W-1:0]  stray_count;

  int checks = 0;
  int errors = 0;

  dmi_timeout_bridge #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_req_valid   (in_req_valid),
    .in_req_ready   (in_req_ready),
    .in_req_addr    (in_req_addr),
    .in_req_op      (in_req_op),
    .in_req_data    (in_req_data),
    .in_resp_valid  (in_resp_valid),
    .in_resp_ready  (in_resp_ready),
    .in_resp_resp   (in_resp_resp),
    .in_resp_data   (in_resp_data),
    .out_req_valid  (out_req_valid),
    .out_req_ready  (out_req_ready),
    .out_req_addr   (out_req_addr),
    .out_req_op     (out_req_op),
    .out_req_data   (out_req_data),
    .out_resp_valid (out_resp_valid),
    .out_resp_ready (out_resp_ready),
    .out_resp_resp  (out_resp_resp),
    .out_resp_data  (out_resp_data),
    .timeout_count  (timeout_count),
    .stray_count    (stray_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] pack_dut();
    return {in_req_ready, out_req_valid, out_req_addr, out_req_op, out_req_data,
            out_resp_ready, in_resp_valid, in_resp_resp, in_resp_data,
            timeout_count, stray_count};
  endfunction

  // ---------------- transaction-level reference model ----------------
  // The bridge is described by what it is currently doing for the host:
  // holding a request downstream, waiting for the DM (with cycles already
  // waited), holding a reply upstream, or ignoring the DM for a drain window.
  bit                m_fwd;
  int                m_waited;       // -1 when not waiting on the DM
  bit                m_ret;
  bit                m_owe_drain;
  int                m_drain_left;
  bit                m_started;
  logic [ADDR_W-1:0] m_addr;
  logic [1:0]        m_op;
  logic [31:0]       m_wdata;
  logic [1:0]        m_resp;
  logic [31:0]       m_rdata;
  int                m_tmo;
  int                m_stray;

  function automatic bit m_idle();
    return !m_fwd && (m_waited < 0) && !m_ret && (m_drain_left == 0);
  endfunction

  function automatic logic [OUT_W-1:0] pack_model();
    logic [CNT_W-1:0] t, s;
    t = CNT_W'(m_tmo);
    s = CNT_W'(m_stray);
    return {m_idle(), m_fwd, m_addr, m_op, m_wdata, (m_started && !m_ret), m_ret,
            m_resp, m_rdata, t, s};
  endfunction

  task automatic model_step();
    bit hs;
    if (reset) begin
      m_fwd = 0; m_waited = -1; m_ret = 0; m_owe_drain = 0; m_drain_left = 0;
      m_started = 0; m_addr = '0; m_op = '0; m_wdata = '0; m_resp = '0; m_rdata = '0;
      m_tmo = 0; m_stray = 0;
      return;
    end
    hs = out_resp_valid && m_started && !m_ret;
    m_started = 1;
    if (m_idle()) begin
      if (hs && m_stray < CNT_MAX) m_stray++;
      if (in_req_valid) begin
        m_addr = in_req_addr; m_op = in_req_op; m_wdata = in_req_data; m_fwd = 1;
      end
    end else if (m_fwd) begin
      if (hs && m_stray < CNT_MAX) m_stray++;
      if (out_req_ready) begin
        m_fwd = 0; m_waited = 0;
      end
    end else if (m_waited >= 0) begin
      if (hs) begin
        m_resp = out_resp_resp; m_rdata = out_resp_data; m_ret = 1; m_waited = -1;
      end else if (m_waited + 1 == TIMEOUT) begin
        m_resp = DMI_RESP_FAILED; m_rdata = '0; m_ret = 1; m_waited = -1;
        m_owe_drain = 1;
        if (m_tmo < CNT_MAX) m_tmo++;
      end else begin
        m_waited++;
      end
    end else if (m_ret) begin
      if (in_resp_ready) begin
        m_ret = 0;
        if (m_owe_drain) begin
          m_drain_left = TIMEOUT; m_owe_drain = 0;
        end
      end
    end else begin
      if (hs) m_drain_left = 0;
      else    m_drain_left--;
    end
  endtask

  // One clock: advance the model on the current inputs, then compare after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("model", pack_dut(), pack_model());
  endtask

  task automatic drive(input logic rq_v, input logic [ADDR_W-1:0] a, input logic [1:0] op,
                       input logic [31:0] wd, input logic oq, input logic rsv,
                       input logic [1:0] rs, input logic [31:0] rd);
    in_req_valid = rq_v; in_req_addr = a; in_req_op = op; in_req_data = wd;
    out_req_ready = oq; out_resp_valid = rsv; out_resp_resp = rs; out_resp_data = rd;
  endtask

  task automatic quiet();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic              rq_v;
    logic [ADDR_W-1:0] a;
    logic [1:0]        op;
    logic [31:0]       wd;
    logic              oq;
    logic              rsv;
    logic [1:0]        rs;
    logic [31:0]       rd;
    logic [OUT_W-1:0]  exp;
  } vec_t;

  function automatic vec_t mk(input logic rq_v, input logic [ADDR_W-1:0] a, input logic [1:0] op,
                              input logic [31:0] wd, input logic oq, input logic rsv,
                              input logic [1:0] rs, input logic [31:0] rd,
                              input logic e_irq, input logic e_orq, input logic [ADDR_W-1:0] e_a,
                              input logic [1:0] e_op, input logic [31:0] e_wd, input logic e_ors,
                              input logic e_irs, input logic [1:0] e_rs, input logic [31:0] e_rd);
    vec_t v;
    v.rq_v = rq_v; v.a = a; v.op = op; v.wd = wd; v.oq = oq; v.rsv = rsv; v.rs = rs; v.rd = rd;
    v.exp = {e_irq, e_orq, e_a, e_op, e_wd, e_ors, e_irs, e_rs, e_rd, CNT_W'(0), CNT_W'(0)};
    return v;
  endfunction

  vec_t tbl[13];
  int   n;
  bit   seen;
  int   pct_tbl[6] = '{5, 25, 60, 15, 40, 10};

  initial begin
    // in_resp_ready is held high for the whole table.
    tbl[0]  = mk(1, 7'h11, DMI_OP_READ,  32'h0,        0, 0, 2'd0, 32'h0,
                 0, 1, 7'h11, DMI_OP_READ,  32'h0,        1, 0, 2'd0, 32'h0);
    tbl[1]  = mk(0, 7'h00, 2'd0,         32'h0,        1, 0, 2'd0, 32'h0,
                 0, 0, 7'h11, DMI_OP_READ,  32'h0,        1, 0, 2'd0, 32'h0);
    tbl[2]  = mk(0, 7'h00, 2'd0,         32'h0,        1, 0, 2'd0, 32'h0,
                 0, 0, 7'h11, DMI_OP_READ,  32'h0,        1, 0, 2'd0, 32'h0);
    tbl[3]  = mk(0, 7'h00, 2'd0,         32'h0,        0, 1, DMI_RESP_SUCCESS, 32'hDEADBEEF,
                 0, 0, 7'h11, DMI_OP_READ,  32'h0,        0, 1, DMI_RESP_SUCCESS, 32'hDEADBEEF);
    tbl[4]  = mk(0, 7'h00, 2'd0,         32'h0,        0, 0, 2'd0, 32'h0,
                 1, 0, 7'h11, DMI_OP_READ,  32'h0,        1, 0, DMI_RESP_SUCCESS, 32'hDEADBEEF);
    tbl[5]  = mk(1, 7'h7F, DMI_OP_NOP,   32'h12345678, 0, 0, 2'd0, 32'h0,
                 0, 1, 7'h7F, DMI_OP_NOP,   32'h12345678, 1, 0, DMI_RESP_SUCCESS, 32'hDEADBEEF);
    tbl[6]  = mk(0, 7'h00, 2'd0,         32'h0,        1, 0, 2'd0, 32'h0,
                 0, 0, 7'h7F, DMI_OP_NOP,   32'h12345678, 1, 0, DMI_RESP_SUCCESS, 32'hDEADBEEF);
    tbl[7]  = mk(0, 7'h00, 2'd0,         32'h0,        0, 1, DMI_RESP_FAILED, 32'hCAFEF00D,
                 0, 0, 7'h7F, DMI_OP_NOP,   32'h12345678, 0, 1, DMI_RESP_FAILED, 32'hCAFEF00D);
    tbl[8]  = mk(0, 7'h00, 2'd0,         32'h0,        0, 0, 2'd0, 32'h0,
                 1, 0, 7'h7F, DMI_OP_NOP,   32'h12345678, 1, 0, DMI_RESP_FAILED, 32'hCAFEF00D);
    tbl[9]  = mk(1, 7'h05, 2'd3,         32'hA5A5A5A5, 1, 0, 2'd0, 32'h0,
                 0, 1, 7'h05, 2'd3,         32'hA5A5A5A5, 1, 0, DMI_RESP_FAILED, 32'hCAFEF00D);
    tbl[10] = mk(0, 7'h00, 2'd0,         32'h0,        1, 0, 2'd0, 32'h0,
                 0, 0, 7'h05, 2'd3,         32'hA5A5A5A5, 1, 0, DMI_RESP_FAILED, 32'hCAFEF00D);
    tbl[11] = mk(0, 7'h00, 2'd0,         32'h0,        0, 1, DMI_RESP_SUCCESS, 32'h1,
                 0, 0, 7'h05, 2'd3,         32'hA5A5A5A5, 0, 1, DMI_RESP_SUCCESS, 32'h1);
    tbl[12] = mk(0, 7'h00, 2'd0,         32'h0,        0, 0, 2'd0, 32'h0,
                 1, 0, 7'h05, 2'd3,         32'hA5A5A5A5, 1, 0, DMI_RESP_SUCCESS, 32'h1);

    // Reset: only in_req_ready (IDLE) is high; valids, out_resp_ready, latches, counters 0.
    reset = 1'b1;
    quiet();
    tick();
    check("reset_state", pack_dut(), {1'b1, {(OUT_W-1){1'b0}}});
    tick();
    reset = 1'b0;
    tick();

    // Table-driven basic transactions.
    in_resp_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].rq_v, tbl[i].a, tbl[i].op, tbl[i].wd, tbl[i].oq, tbl[i].rsv, tbl[i].rs, tbl[i].rd);
      tick();
      check($sformatf("table_row%0d", i), pack_dut(), tbl[i].exp);
    end
    quiet();
    in_resp_ready = 1'b0;

    // Silent DM: exactly TIMEOUT waiting cycles, FAILED reply, late response drained.
    drive(1, 7'h22, DMI_OP_READ, 32'h0, 0, 0, 2'd0, 32'h0);
    tick();
    drive(0, 7'h00, 2'd0, 32'h0, 1, 0, 2'd0, 32'h0);
    tick();
    quiet();
    n = 0;
    while (!in_resp_valid && n < 50) begin
      n++;
      tick();
    end
    check("timeout_wait_cycles", n, TIMEOUT);
    check("timeout_resp", {in_resp_resp, in_resp_data}, {DMI_RESP_FAILED, 32'h0});
    check("timeout_count_one", timeout_count, 1);
    in_resp_ready = 1'b1;
    tick();
    in_resp_ready = 1'b0;
    tick();
    tick();
    drive(0, 7'h00, 2'd0, 32'h0, 0, 1, DMI_RESP_SUCCESS, 32'h00000BAD);
    tick();
    quiet();
    check("late_resp_drained", {stray_count, in_req_ready, in_resp_valid}, {CNT_W'(0), 1'b1, 1'b0});
    drive(1, 7'h10, DMI_OP_WRITE, 32'h1, 0, 0, 2'd0, 32'h0);
    tick();
    check("write_after_timeout", {out_req_valid, out_req_addr, out_req_op, out_req_data},
          {1'b1, 7'h10, DMI_OP_WRITE, 32'h1});
    drive(0, 7'h00, 2'd0, 32'h0, 1, 0, 2'd0, 32'h0);
    tick();
    drive(0, 7'h00, 2'd0, 32'h0, 0, 1, DMI_RESP_SUCCESS, 32'h0);
    tick();
    quiet();
    check("write_reply", {in_resp_valid, in_resp_resp}, {1'b1, DMI_RESP_SUCCESS});
    in_resp_ready = 1'b1;
    tick();
    in_resp_ready = 1'b0;

    // Response on the last waiting cycle wins over the timeout.
    drive(1, 7'h23, DMI_OP_READ, 32'h0, 0, 0, 2'd0, 32'h0);
    tick();
    drive(0, 7'h00, 2'd0, 32'h0, 1, 0, 2'd0, 32'h0);
    tick();
    quiet();
    repeat (TIMEOUT - 1) tick();
    check("pre_expiry_still_waiting", in_resp_valid, 1'b0);
    drive(0, 7'h00, 2'd0, 32'h0, 0, 1, DMI_RESP_BUSY, 32'h55);
    tick();
    quiet();
    check("expiry_race_reply", {in_resp_valid, in_resp_resp, in_resp_data, timeout_count},
          {1'b1, DMI_RESP_BUSY, 32'h55, CNT_W'(1)});
    in_resp_ready = 1'b1;
    tick();
    in_resp_ready = 1'b0;
    check("expiry_race_no_drain", in_req_ready, 1'b1);

    // Backpressure on both sides.
    drive(1, 7'h33, DMI_OP_WRITE, 32'h0BADF00D, 0, 0, 2'd0, 32'h0);
    tick();
    quiet();
    n = 0;
    repeat (20) begin
      tick();
      if (out_req_valid && out_req_addr == 7'h33 && out_req_op == DMI_OP_WRITE &&
          out_req_data == 32'h0BADF00D) n++;
    end
    check("req_backpressure_stable", n, 20);
    check("req_backpressure_no_timeout", timeout_count, 1);
    drive(0, 7'h00, 2'd0, 32'h0, 1, 0, 2'd0, 32'h0);
    tick();
    drive(0, 7'h00, 2'd0, 32'h0, 0, 1, DMI_RESP_SUCCESS, 32'h13579BDF);
    tick();
    quiet();
    n = 0;
    repeat (5) begin
      tick();
      if (in_resp_valid && in_resp_resp == DMI_RESP_SUCCESS && in_resp_data == 32'h13579BDF) n++;
    end
    check("resp_backpressure_stable", n, 5);
    in_resp_ready = 1'b1;
    tick();
    in_resp_ready = 1'b0;
    check("resp_backpressure_done", in_req_ready, 1'b1);

    // Unsolicited DM responses while idle, up to saturation.
    drive(0, 7'h00, 2'd0, 32'h0, 0, 1, DMI_RESP_SUCCESS, 32'h77);
    tick();
    quiet();
    check("stray_one", {stray_count, in_resp_valid}, {CNT_W'(1), 1'b0});
    drive(0, 7'h00, 2'd0, 32'h0, 0, 1, DMI_RESP_SUCCESS, 32'h78);
    seen = 0;
    repeat ((1 << CNT_W) + 3) begin
      tick();
      if (in_resp_valid) seen = 1;
    end
    quiet();
    tick();
    check("stray_saturated", stray_count, CNT_MAX);
    check("stray_never_returned", seen, 1'b0);

    // One-cycle reset while waiting on the DM.
    drive(1, 7'h24, DMI_OP_READ, 32'h0, 0, 0, 2'd0, 32'h0);
    tick();
    drive(0, 7'h00, 2'd0, 32'h0, 1, 0, 2'd0, 32'h0);
    tick();
    quiet();
    tick();
    reset = 1'b1;
    tick();
    check("reset_mid_resp", {in_req_ready, out_req_valid, in_resp_valid, timeout_count, stray_count},
          {1'b1, 1'b0, 1'b0, CNT_W'(0), CNT_W'(0)});
    reset = 1'b0;
    drive(1, 7'h44, DMI_OP_READ, 32'h0, 0, 0, 2'd0, 32'h0);
    tick();
    check("accept_after_reset", {out_req_valid, out_req_addr}, {1'b1, 7'h44});
    drive(0, 7'h00, 2'd0, 32'h0, 1, 0, 2'd0, 32'h0);
    tick();
    drive(0, 7'h00, 2'd0, 32'h0, 0, 1, DMI_RESP_SUCCESS, 32'h9);
    tick();
    quiet();
    in_resp_ready = 1'b1;
    tick();

    // Randomized traffic against the model, with varying DM responsiveness.
    for (int seg = 0; seg < 6; seg++) begin
      repeat (500) begin
        reset          = ($urandom_range(0, 199) == 0);
        in_req_valid   = ($urandom_range(0, 1) == 1);
        in_req_addr    = ADDR_W'($urandom);
        in_req_op      = 2'($urandom);
        in_req_data    = $urandom;
        out_req_ready  = ($urandom_range(0, 99) < 60);
        out_resp_valid = ($urandom_range(0, 99) < pct_tbl[seg]);
        out_resp_resp  = 2'($urandom);
        out_resp_data  = $urandom;
        in_resp_ready  = ($urandom_range(0, 99) < 60);
        tick();
      end
    end
    reset = 1'b0;
    quiet();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
